// File: rtl/picomem_arbiter_4_1.sv
// Four-master round-robin arbiter for the PicoRV32 native memory interface.
// Optional watchdog: define PICOMEM_ARB_TIMEOUT_EN to terminate stalled transfers.
module picomem_arbiter_4_1 #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        picom0_valid,
  input  logic [31:0] picom0_addr,
  input  logic [31:0] picom0_wdata,
  input  logic [3:0]  picom0_wstrb,
  output logic        picom0_ready,
  output logic [31:0] picom0_rdata,

  input  logic        picom1_valid,
  input  logic [31:0] picom1_addr,
  input  logic [31:0] picom1_wdata,
  input  logic [3:0]  picom1_wstrb,
  output logic        picom1_ready,
  output logic [31:0] picom1_rdata,

  input  logic        picom2_valid,
  input  logic [31:0] picom2_addr,
  input  logic [31:0] picom2_wdata,
  input  logic [3:0]  picom2_wstrb,
  output logic        picom2_ready,
  output logic [31:0] picom2_rdata,

  input  logic        picom3_valid,
  input  logic [31:0] picom3_addr,
  input  logic [31:0] picom3_wdata,
  input  logic [3:0]  picom3_wstrb,
  output logic        picom3_ready,
  output logic [31:0] picom3_rdata,

  output logic        picos_valid,
  output logic [31:0] picos_addr,
  output logic [31:0] picos_wdata,
  output logic [3:0]  picos_wstrb,
  input  logic        picos_ready,
  input  logic [31:0] picos_rdata,

  output logic [1:0]  grant_idx,
  output logic        err_timeout
);

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("picomem_arbiter_4_1: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state, state_nxt;
  logic [1:0]      grant_nxt;
  logic [1:0]      last_idx, last_nxt;
  logic [1:0]      pick_idx;
  logic            pick_vld;
  logic            wdog_hit_c;
  logic            timeout_c;

  logic [NM-1:0]   m_valid;
  logic [AW-1:0]   m_addr  [NM];
  logic [DW-1:0]   m_wdata [NM];
  logic [SW-1:0]   m_wstrb [NM];
  logic [NM-1:0]   m_ready_c;
  logic [DW-1:0]   m_rdata_c [NM];

  // Gather master ports into indexable arrays
  always_comb begin
    m_valid    = {picom3_valid, picom2_valid, picom1_valid, picom0_valid};
    m_addr[0]  = picom0_addr;   m_addr[1]  = picom1_addr;
    m_addr[2]  = picom2_addr;   m_addr[3]  = picom3_addr;
    m_wdata[0] = picom0_wdata;  m_wdata[1] = picom1_wdata;
    m_wdata[2] = picom2_wdata;  m_wdata[3] = picom3_wdata;
    m_wstrb[0] = picom0_wstrb;  m_wstrb[1] = picom1_wstrb;
    m_wstrb[2] = picom2_wstrb;  m_wstrb[3] = picom3_wstrb;
  end

  assign picom0_ready = m_ready_c[0];
  assign picom1_ready = m_ready_c[1];
  assign picom2_ready = m_ready_c[2];
  assign picom3_ready = m_ready_c[3];
  assign picom0_rdata = m_rdata_c[0];
  assign picom1_rdata = m_rdata_c[1];
  assign picom2_rdata = m_rdata_c[2];
  assign picom3_rdata = m_rdata_c[3];
  assign err_timeout  = timeout_c;

  // Round-robin pick: first requester after the last grantee
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_idx;
    for (int i = 1; i <= 4; i++) begin
      if (!pick_vld && m_valid[2'(last_idx + 2'(i))]) begin
        pick_vld = 1'b1;
        pick_idx = 2'(last_idx + 2'(i));
      end
    end
  end

`ifdef PICOMEM_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_cnt, wdog_nxt;

  // Counts BUSY cycles without slave ready; held at zero while idle
  always_comb begin
    wdog_nxt = wdog_cnt;
    if (state == S_IDLE)  wdog_nxt = 16'd0;
    else if (!picos_ready) wdog_nxt = 16'(wdog_cnt + 16'd1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wdog_cnt <= 16'd0;
    else         wdog_cnt <= wdog_nxt;
  end

  assign wdog_hit_c = (wdog_cnt == WDOG_LIM);
`else
  assign wdog_hit_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      grant_idx <= 2'd0;
      last_idx  <= 2'd3;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      last_idx  <= last_nxt;
    end
  end

  // Next state plus the combinational slave/master routing
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_idx;
    last_nxt    = last_idx;
    timeout_c   = 1'b0;
    picos_valid = 1'b0;
    picos_addr  = '0;
    picos_wdata = '0;
    picos_wstrb = '0;
    m_ready_c   = '0;
    for (int i = 0; i < NM; i++) m_rdata_c[i] = '0;

    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_idx;
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        // A real slave ready wins over a watchdog expiry in the same cycle
        timeout_c              = wdog_hit_c & m_valid[grant_idx] & ~picos_ready;
        picos_valid            = m_valid[grant_idx] & ~timeout_c;
        picos_addr             = m_addr[grant_idx];
        picos_wdata            = m_wdata[grant_idx];
        picos_wstrb            = m_wstrb[grant_idx];
        m_ready_c[grant_idx]   = picos_ready | timeout_c;
        m_rdata_c[grant_idx]   = timeout_c ? TIMEOUT_RDATA : picos_rdata;
        if (!m_valid[grant_idx] || picos_ready || timeout_c) begin
          state_nxt = S_IDLE;
          last_nxt  = grant_idx;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/picomem_arbiter_4_1.md
# picomem_arbiter_4_1

Four-master to one-slave arbiter for the PicoRV32 native memory interface (valid/ready/addr/wdata/wstrb/rdata). Sits upstream of a shared slave (e.g. the peripheral mux or shared RAM) so that the core, a DMA engine and debug/boot masters can share one slave port. Round-robin arbitration with the grant held for a whole transaction, and an optional watchdog that terminates stalled transfers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1024: watchdog limit in BUSY cycles, range 2..65535. Used only with the watchdog macro.
- `TIMEOUT_RDATA`, 32'hDEAD_BEEF: rdata returned to a master on a watchdog-terminated transfer.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `picomN_valid` in 1 (N=0..3): master N request.
- `picomN_addr` in 32, `picomN_wdata` in 32, `picomN_wstrb` in 4: master N request fields.
- `picomN_ready` out 1: master N transfer complete.
- `picomN_rdata` out 32: master N read data.
- `picos_valid` out 1: slave request.
- `picos_addr` out 32, `picos_wdata` out 32, `picos_wstrb` out 4: slave request fields.
- `picos_ready` in 1, `picos_rdata` in 32: slave response.
- `grant_idx` out 2: index of the current or most recent grantee.
- `err_timeout` out 1: one-cycle pulse when the watchdog terminates a transfer.

## Operation
- States: IDLE, BUSY. Registers: `state`, `grant_idx`, `last_idx` (2b), watchdog counter (16b, macro only).
- IDLE: if any `picomN_valid`, choose the first requester in the order `last_idx+1, +2, +3, +4` (mod 4). Latch it into `grant_idx`, then go to BUSY. No slave signals are driven in IDLE.
- BUSY: `picos_valid = picom[g]_valid`; `picos_addr/wdata/wstrb` = master g fields (combinational). `picom[g]_ready = picos_ready` and `picom[g]_rdata = picos_rdata`.
- BUSY, `picos_ready`=1: at the next edge `last_idx <= g` and the state goes to IDLE.
- BUSY, `picom[g]_valid`=0 before ready (abort): at the next edge the state goes to IDLE, `last_idx <= g`, and no ready is issued.
- Non-granted masters see `ready`=0 and `rdata`=0. In IDLE, all `picos_*` outputs are 0.
- Requests from other masters while BUSY are ignored until IDLE. They are not queued.
- Reset (asynchronous, any time, including mid-transfer): `state`=IDLE, `grant_idx`=0, `last_idx`=3 (so master 0 has first priority), counter=0. Every output is 0.
- An in-flight slave transfer cut by reset is abandoned. Slave state is not the arbiter's concern.

## Timing
- Arbitration latency is 1 cycle: a request first seen in IDLE at edge k gets `picos_valid`=1 from edge k onward (cycle k+1).
- Ready passthrough is zero-latency, from slave to master in the same cycle.
- Minimum transfer is 2 cycles (1 arbitration + 1 with `picos_ready`). Back-to-back grants need 1 IDLE cycle between them.
- A master holding `valid` across its own ready cycle re-arbitrates in the following IDLE cycle. Under PicoRV32 rules `valid` drops after ready, so there is no double issue.
- Fairness: with all four masters requesting continuously, grants cycle 0,1,2,3,0,… and no master waits more than 3 transfers.

## Configuration
- `PICOMEM_ARB_TIMEOUT_EN` defined:
  - The counter clears on entry to BUSY and increments each BUSY cycle without `picos_ready`.
  - In the cycle the count equals `TIMEOUT_CYCLES-1` and `picos_ready`=0:
    - `picom[g]_ready`=1 and `picom[g]_rdata`=`TIMEOUT_RDATA`.
    - `picos_valid` is forced to 0.
    - `err_timeout`=1.
  - The next edge goes to IDLE with `last_idx <= g`.
  - A `picos_ready` arriving in that same cycle takes precedence: normal completion, no error.
- Not defined: no counter is built, `err_timeout` is tied to 0, and BUSY waits indefinitely.

## Test plan
- Reset with master 1 reading `0x8000_0010` and the slave returning `0x1234_5678` after 3 cycles:
  - `picos_valid` rises 1 cycle after request.
  - `picom1_ready`=1 with rdata `0x1234_5678` for exactly 1 cycle.
  - All other masters' ready and rdata stay 0.
- Masters 0 and 2 request in the same IDLE cycle after reset: master 0 is served first, then master 2. `grant_idx` sequence 0,2.
- All four masters write continuously, with the slave ready on the first BUSY cycle: grants 0,1,2,3,0,1. Each transfer takes 2 cycles. `wstrb`/`wdata` pass through unchanged.
- Master 3 drops `valid` in BUSY before `picos_ready`: the state returns to IDLE, `picom3_ready` is never asserted, and the next grant goes to master 0.
- `resetn` is pulsed low mid-BUSY while master 2 is granted: outputs go to 0 immediately, asynchronously. After release, a pending master 2 request is granted again from IDLE.
- With `PICOMEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, the slave never readies:
  - In the 8th BUSY cycle, `picom0_ready`=1, rdata `0xDEAD_BEEF`, `err_timeout`=1 pulse.
  - Without the macro, BUSY persists beyond 100 cycles.
